// File: rtl/wb_regfile.sv
// Writeback select and 16x16 architectural register file with two combinational read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] memdata,
  input  logic [DATA_W-1:0] aluresult,
  input  logic [ADDR_W-1:0] regdst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] wbdata,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [NREGS];
  logic              commit;

  assign wbdata = memtoreg ? memdata : aluresult;

  // Gating on commit keeps X data on an idle writeback out of the array.
  assign commit = regwrite && (regdst != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (commit) begin
      regs[regdst] <= wbdata;
      wr_count     <= wr_count + CNT_ONE;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end
`ifdef WB_REGFILE_BYPASS_EN
    else if (commit && (raddr1 == regdst)) begin
      rdata1 = wbdata;
    end
`endif
    if (raddr2 == '0) begin
      rdata2 = '0;
    end
`ifdef WB_REGFILE_BYPASS_EN
    else if (commit && (raddr2 == regdst)) begin
      rdata2 = wbdata;
    end
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; the counter is built narrow (CNT_W=4)
// so the wrap case is reached in a handful of commits.
module tb_wb_regfile;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          regwrite;
  logic          memtoreg;
  logic [DW-1:0] memdata;
  logic [DW-1:0] aluresult;
  logic [AW-1:0] regdst;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] wbdata;
  logic [CW-1:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NREGS(16), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .regwrite  (regwrite),
    .memtoreg  (memtoreg),
    .memdata   (memdata),
    .aluresult (aluresult),
    .regdst    (regdst),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .wbdata    (wbdata),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] dst, input logic m2r, input logic [DW-1:0] val);
    regwrite  = 1'b1;
    regdst    = dst;
    memtoreg  = m2r;
    memdata   = m2r ? val : 16'h0F0F;
    aluresult = m2r ? 16'hF0F0 : val;
    tick();
    regwrite  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; regwrite = 1'b0; memtoreg = 1'b0;
    memdata = '0; aluresult = '0; regdst = '0; raddr1 = '0; raddr2 = '0;
    tick();
    rst = 1'b0;

    // populate, then reset for two cycles
    wr(4'd2, 1'b0, 16'h1111);
    wr(4'd6, 1'b1, 16'h2222);
    wr(4'd15, 1'b0, 16'h3333);
    chk("pre_reset_cnt", 32'(wr_count), 32'd3);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      raddr1 = AW'(i); raddr2 = AW'(15 - i);
      #1;
      chk($sformatf("reset_rd1_r%0d", i), 32'(rdata1), 32'd0);
      chk($sformatf("reset_rd2_r%0d", 15 - i), 32'(rdata2), 32'd0);
    end
    chk("reset_cnt", 32'(wr_count), 32'd0);

    // writeback mux, independent of regwrite
    memtoreg = 1'b0; aluresult = 16'h1234; memdata = 16'hBEEF; #1;
    chk("wbdata_alu", 32'(wbdata), 32'h1234);
    memtoreg = 1'b1; #1;
    chk("wbdata_mem", 32'(wbdata), 32'hBEEF);

    // basic writes
    wr(4'd5, 1'b0, 16'h1234);
    raddr1 = 4'd5; #1;
    chk("r5_alu", 32'(rdata1), 32'h1234);
    chk("cnt_1", 32'(wr_count), 32'd1);
    wr(4'd7, 1'b1, 16'hBEEF);
    raddr1 = 4'd7; raddr2 = 4'd7; #1;
    chk("r7_mem_p1", 32'(rdata1), 32'hBEEF);
    chk("r7_mem_p2", 32'(rdata2), 32'hBEEF);
    chk("cnt_2", 32'(wr_count), 32'd2);

    // r0 protection, including no bypass on index 0
    regwrite = 1'b1; regdst = 4'd0; memtoreg = 1'b0; aluresult = 16'hFFFF;
    raddr1 = 4'd0; #1;
    chk("r0_same_cycle", 32'(rdata1), 32'd0);
    tick();
    regwrite = 1'b0; #1;
    chk("r0_after", 32'(rdata1), 32'd0);
    chk("cnt_r0", 32'(wr_count), 32'd2);

    // same-cycle read during write
    wr(4'd3, 1'b0, 16'h0001);
    regwrite = 1'b1; regdst = 4'd3; memtoreg = 1'b0; aluresult = 16'h00AA;
    raddr2 = 4'd3; #1;
`ifdef WB_REGFILE_BYPASS_EN
    chk("rdw_before", 32'(rdata2), 32'h00AA);
`else
    chk("rdw_before", 32'(rdata2), 32'h0001);
`endif
    tick();
    regwrite = 1'b0; #1;
    chk("rdw_after", 32'(rdata2), 32'h00AA);
    chk("cnt_4", 32'(wr_count), 32'd4);

    // idle writeback with X data leaves state untouched
    regwrite = 1'b0; regdst = 4'd5; memdata = 'x; aluresult = 'x;
    tick();
    raddr1 = 4'd5; #1;
    chk("x_idle_r5", 32'(rdata1), 32'h1234);
    chk("x_idle_cnt", 32'(wr_count), 32'd4);

    // reset beats a simultaneous write
    rst = 1'b1; regwrite = 1'b1; regdst = 4'd9; memtoreg = 1'b0; aluresult = 16'h5555;
    tick();
    rst = 1'b0; regwrite = 1'b0;
    raddr1 = 4'd9; raddr2 = 4'd5; #1;
    chk("coll_r9", 32'(rdata1), 32'd0);
    chk("coll_r5", 32'(rdata2), 32'd0);
    chk("coll_cnt", 32'(wr_count), 32'd0);

    // counter wrap at 2**CW-1
    for (int i = 0; i < 15; i++) begin
      wr(AW'((i % 15) + 1), 1'b0, DW'(i + 16'h0100));
    end
    chk("cnt_15", 32'(wr_count), 32'd15);
    raddr1 = 4'd4; #1;
    chk("r4_loop", 32'(rdata1), 32'h0103);
    wr(4'd10, 1'b1, 16'hC0DE);
    raddr1 = 4'd10; #1;
    chk("cnt_wrap", 32'(wr_count), 32'd0);
    chk("wrap_r10", 32'(rdata1), 32'hC0DE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
